serial_word_comparator: RTL and testbench

SERIAL_WORD_COMPARATOR -- requirements
Module: serial_word_comparator

---
 rtl/serial_word_comparator_if.sv | 25 ++
 rtl/serial_word_comparator.sv | 118 +++++++++++
 tb/tb_serial_word_comparator.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/serial_word_comparator_if.sv
// Bit-serial comparator bus: per-bit operand stream and mode controls in,
// frame status and registered compare result out.
interface serial_word_comparator_if;
    logic in_valid;
    logic a;
    logic b;
    logic msb_first;
    logic signed_cmp;
    logic abort;
    logic busy;
    logic res_valid;
    logic res_lt;
    logic res_eq;
    logic res_gt;

    modport master (
        output in_valid, a, b, msb_first, signed_cmp, abort,
        input  busy, res_valid, res_lt, res_eq, res_gt
    );

    modport slave (
        input  in_valid, a, b, msb_first, signed_cmp, abort,
        output busy, res_valid, res_lt, res_eq, res_gt
    );
endinterface

// File: rtl/serial_word_comparator.sv
// Compares two W-bit words streamed one bit pair per accepted cycle,
// MSB- or LSB-first, unsigned or two's complement, with abort and stall.
module serial_word_comparator #(
    parameter int W = 8
) (
    input logic                     clk,
    input logic                     rst,
    serial_word_comparator_if.slave bus
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, EQ, LT, GT} state_t;

    state_t          state_q, state_d;
    state_t          decision;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            msb_q, msb_d;
    logic            sgn_q, sgn_d;

    logic            busy_q, valid_q, lt_q, eq_q, gt_q;
    logic            load;
    logic            lt_d, eq_d, gt_d;

    logic            first_bit, last_bit;
    logic            eff_msb, eff_sgn;
    logic            inv, bit_gt, bit_lt;

    assign first_bit = (cnt_q == '0);
    assign last_bit  = (cnt_q == LAST_IDX);
    // On the first bit the mode comes straight from the pins; afterwards from the latch.
    assign eff_msb   = first_bit ? bus.msb_first  : msb_q;
    assign eff_sgn   = first_bit ? bus.signed_cmp : sgn_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            msb_q   <= 1'b0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            msb_q   <= msb_d;
            sgn_q   <= sgn_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        msb_d    = msb_q;
        sgn_d    = sgn_q;
        decision = (state_q == IDLE) ? EQ : state_q;

        // The sign bit carries the opposite weight in two's complement.
        inv    = eff_sgn & (eff_msb ? first_bit : last_bit);
        bit_gt = inv ? (~bus.a & bus.b) : (bus.a & ~bus.b);
        bit_lt = inv ? (bus.a & ~bus.b) : (~bus.a & bus.b);

        // MSB-first: first difference decides. LSB-first: last difference decides.
        if (!eff_msb || decision == EQ) begin
            if (bit_gt) begin
                decision = GT;
            end else if (bit_lt) begin
                decision = LT;
            end
        end

        if (bus.abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (bus.in_valid) begin
            if (first_bit) begin
                msb_d = bus.msb_first;
                sgn_d = bus.signed_cmp;
            end
            if (last_bit) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = decision;
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        load = bus.in_valid & ~bus.abort & last_bit;
        lt_d = (decision == LT);
        eq_d = (decision == EQ);
        gt_d = (decision == GT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            busy_q  <= (cnt_d != '0);
            valid_q <= load;
            if (load) begin
                lt_q <= lt_d;
                eq_q <= eq_d;
                gt_q <= gt_d;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.res_valid = valid_q;
    assign bus.res_lt    = lt_q;
    assign bus.res_eq    = eq_q;
    assign bus.res_gt    = gt_q;
endmodule

// File: tb/tb_serial_word_comparator.sv
// Directed bench: a word-level reference model checked every cycle plus
// literal expectations for each hand-computed frame.
module tb_serial_word_comparator;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_word_comparator_if bus();

    serial_word_comparator #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int pulse_cyc = 0;
    bit started = 1'b0;

    // Reference model: assemble both words, then compare them as integers.
    int           m_n = 0;
    bit           m_msb = 1'b0;
    bit           m_sgn = 1'b0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    bit exp_busy = 1'b0, exp_valid = 1'b0;
    bit exp_lt = 1'b0, exp_eq = 1'b0, exp_gt = 1'b0;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_n = 0; exp_busy = 0; exp_valid = 0;
            exp_lt = 0; exp_eq = 0; exp_gt = 0;
        end else begin
            exp_valid = 0;
            if (bus.abort) begin
                m_n = 0;
            end else if (bus.in_valid) begin
                if (m_n == 0) begin
                    m_msb = bus.msb_first; m_sgn = bus.signed_cmp;
                    m_a = '0; m_b = '0;
                end
                m_a[m_msb ? (W - 1 - m_n) : m_n] = bus.a;
                m_b[m_msb ? (W - 1 - m_n) : m_n] = bus.b;
                m_n++;
                if (m_n == W) begin
                    int va, vb;
                    va = m_sgn ? int'($signed(m_a)) : int'(m_a);
                    vb = m_sgn ? int'($signed(m_b)) : int'(m_b);
                    exp_lt = va < vb; exp_eq = va == vb; exp_gt = va > vb;
                    exp_valid = 1; m_n = 0;
                end
            end
            exp_busy = (m_n != 0);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("busy",      int'(bus.busy),      int'(exp_busy));
            chk("res_valid", int'(bus.res_valid), int'(exp_valid));
            chk("res_lt",    int'(bus.res_lt),    int'(exp_lt));
            chk("res_eq",    int'(bus.res_eq),    int'(exp_eq));
            chk("res_gt",    int'(bus.res_gt),    int'(exp_gt));
            if (bus.res_valid) begin
                pulse_cnt++;
                pulse_cyc = cyc;
            end
        end
    end

    task automatic step(input logic v, ia, ib, im, is, iab);
        bus.in_valid = v; bus.a = ia; bus.b = ib;
        bus.msb_first = im; bus.signed_cmp = is; bus.abort = iab;
        @(posedge clk);
        #1;
    endtask

    // Streams nbits of a frame; mode pins flip after the first bit to prove latching.
    task automatic send_frame(input logic [W-1:0] fa, fb, input bit msb, sgn,
                              input int nbits, input bit stall);
        for (int i = 0; i < nbits; i++) begin
            int p;
            p = msb ? (W - 1 - i) : i;
            step(1'b1, fa[p], fb[p], (i == 0) ? msb : ~msb, (i == 0) ? sgn : ~sgn, 1'b0);
            if (stall && (i == 1 || i == 4)) begin
                for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, ~msb, ~sgn, 1'b0);
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lit(input string name, input bit lt, eq, gt);
        chk({name, "_lt"}, int'(bus.res_lt), int'(lt));
        chk({name, "_eq"}, int'(bus.res_eq), int'(eq));
        chk({name, "_gt"}, int'(bus.res_gt), int'(gt));
    endtask

    int p0, s0;

    initial begin
        bus.in_valid = 0; bus.a = 0; bus.b = 0;
        bus.msb_first = 0; bus.signed_cmp = 0; bus.abort = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_valid", int'(bus.res_valid), 0);
        lit("rst", 0, 0, 0);
        rst = 1'b1;
        started = 1'b1;
        idle(); idle();

        p0 = pulse_cnt;
        send_frame(8'h64, 8'h62, 1, 0, W, 0); idle();
        chk("f64_pulses", pulse_cnt - p0, 1);
        lit("f64", 0, 0, 1);
        $display("frame A=64 B=62 msb unsigned lt=%0b eq=%0b gt=%0b", bus.res_lt, bus.res_eq, bus.res_gt);

        send_frame(8'h80, 8'h7F, 0, 0, W, 0); idle();
        lit("f80u", 0, 0, 1);
        $display("frame A=80 B=7F lsb unsigned lt=%0b eq=%0b gt=%0b", bus.res_lt, bus.res_eq, bus.res_gt);
        send_frame(8'h80, 8'h7F, 0, 1, W, 0); idle();
        lit("f80s", 1, 0, 0);
        $display("frame A=80 B=7F lsb signed lt=%0b eq=%0b gt=%0b", bus.res_lt, bus.res_eq, bus.res_gt);

        p0 = pulse_cnt;
        send_frame(8'hFF, 8'h01, 1, 1, W, 0);
        chk("fFF_lt_b2b", int'(exp_lt), 1);
        send_frame(8'hA5, 8'hA5, 1, 1, W, 0); idle();
        chk("b2b_pulses", pulse_cnt - p0, 2);
        lit("fA5", 0, 1, 0);
        $display("frames FF/01 then A5/A5 msb signed lt=%0b eq=%0b gt=%0b", bus.res_lt, bus.res_eq, bus.res_gt);

        p0 = pulse_cnt; s0 = cyc;
        send_frame(8'h10, 8'h20, 1, 0, W, 1); idle();
        chk("stall_pulses", pulse_cnt - p0, 1);
        chk("stall_latency", pulse_cyc - s0, W + 6);
        lit("f10", 1, 0, 0);
        $display("frame A=10 B=20 msb stalled lt=%0b eq=%0b gt=%0b", bus.res_lt, bus.res_eq, bus.res_gt);

        send_frame(8'h64, 8'h62, 1, 0, W, 0); idle();
        p0 = pulse_cnt;
        send_frame(8'hFF, 8'h00, 1, 0, 4, 0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        chk("abort_pulses", pulse_cnt - p0, 0);
        lit("abort_hold", 0, 0, 1);
        send_frame(8'h01, 8'h02, 1, 0, W, 0); idle();
        chk("post_abort_pulses", pulse_cnt - p0, 1);
        lit("f01", 1, 0, 0);
        $display("abort then A=01 B=02 lt=%0b eq=%0b gt=%0b", bus.res_lt, bus.res_eq, bus.res_gt);

        send_frame(8'hFF, 8'h00, 1, 0, 5, 0);
        #1 rst = 1'b0;
        #1;
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_valid", int'(bus.res_valid), 0);
        lit("arst", 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        send_frame(8'h7E, 8'h81, 1, 1, W, 0); idle();
        lit("f7E", 0, 0, 1);
        $display("reset mid-frame then A=7E B=81 msb signed lt=%0b eq=%0b gt=%0b", bus.res_lt, bus.res_eq, bus.res_gt);

        idle(); idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
